mac_drain: RTL and testbench
============================

MAC_DRAIN -- requirements
Module: mac_drain

Interface
REQ-001 SHALL have parameter MAC_WIDTH, default 8, meaning the PE array dimension (rows = columns).
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the signed accumulator width per PE.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, meaning the signed requantized output element width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a request to snapshot and drain the accumulators; it is honoured only in IDLE.
REQ-007 SHALL have port accumulators, input, MAC_WIDTH*MAC_WIDTH*ACC_WIDTH, the PE (i,j) value at slice [(i*MAC_WIDTH+j)*ACC_WIDTH +: ACC_WIDTH].
REQ-008 SHALL have port shift, input, 5, the requantization right-shift amount, captured at start.
REQ-009 SHALL have port relu_en, input, 1, which clamps negative results to 0; captured at start.
REQ-010 SHALL have port clear_acc, output, 1, a one-cycle pulse telling the array to clear its accumulators.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port out_valid, output, 1, meaning a row is available.
REQ-013 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-014 SHALL have port out_data, output, MAC_WIDTH*OUT_WIDTH, one requantized row, with column j at [j*OUT_WIDTH +: OUT_WIDTH].
REQ-015 SHALL have port out_row, output, clog2(MAC_WIDTH), the index of the row on out_data.
REQ-016 SHALL have port out_last, output, 1, high together with out_valid on row MAC_WIDTH-1.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD and DRAIN.
- IDLE to LOAD on start.
- LOAD to DRAIN unconditionally.
- DRAIN to IDLE on the handshake of row MAC_WIDTH-1.
REQ-018 SHALL, on the edge where start is sampled in IDLE, load the full accumulators vector plus shift and relu_en into snapshot registers.
REQ-019 SHALL hold clear_acc high for exactly the LOAD cycle; later changes on accumulators do not affect the snapshot.
REQ-020 SHALL register out_data, with first out_valid asserted the cycle after LOAD, i.e. 2 cycles after start is sampled, carrying row 0.
REQ-021 SHALL define a handshake as out_valid && out_ready at a rising edge; on a handshake the next row is registered on the same edge, giving 1 row/cycle with no bubbles.
REQ-022 SHALL keep out_data, out_row, out_last and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL drop out_valid on the edge of the last-row handshake and return to IDLE.
REQ-024 SHALL compute each element, with the arithmetic at width ACC_WIDTH+1 signed:
- r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift;
- if relu_en and r<0, then r=0;
- saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-025 SHALL ignore start while busy, including the cycle of the final handshake; no queuing.
REQ-026 SHALL drive out_row from 0 up to MAC_WIDTH-1 in order, with no skipped or repeated rows.

Reset
REQ-027 SHALL, while rst_n is low, immediately force state to IDLE and out_valid, out_last, clear_acc, busy, out_data, out_row and the snapshot registers to 0, regardless of operation in progress.
REQ-028 SHALL accept a start in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL place the MAC_WIDTH, ACC_WIDTH and OUT_WIDTH defaults and the FSM state encodings in shared package mac_pkg, also used by the PE array.
REQ-030 SHALL implement the element arithmetic of REQ-024 as a combinational sub-module acc_requant, instantiated MAC_WIDTH times for one row.

Verification
REQ-031 SHALL cover: all accs=256, shift=4, relu_en=0, out_ready=1 -> out_valid at start+2, 8 consecutive rows of 0x10 bytes, out_last on row 7, busy low at start+10.
REQ-032 SHALL cover: acc=1000 / -1000, shift=0 -> 0x7F / 0x80; with relu_en=1 -> 0x7F / 0x00.
REQ-033 SHALL cover: shift=3, acc=23 -> 3; acc=-20 -> -2 (0xFE); acc=-2^31, shift=31 -> -1 (0xFF), with no wrap.
REQ-034 SHALL cover: out_ready low for 3 cycles while row 2 is presented -> row 2 held unchanged; rows 0..7 each delivered exactly once.
REQ-035 SHALL cover: accumulators changed during and after LOAD, plus a start pulsed during DRAIN -> output matches the start-time snapshot, clear_acc pulses once, and no second drain occurs.
REQ-036 SHALL cover: rst_n asserted while row 3 is valid -> out_valid and busy go 0 with no clock edge; a subsequent start drains from row 0 correctly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC-array definitions: default dimensions and drain FSM encodings,
// common to the PE array and the drain/requantization path.
package mac_pkg;

    localparam int DEF_MAC_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer for one accumulator: rounding arithmetic shift,
// optional ReLU, then saturation to the signed output width.
module acc_requant
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    output logic [OUT_WIDTH-1:0] res_o
);

    localparam int W = ACC_WIDTH + 1;
    localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [W-1:0] ext_s;
    logic signed [W-1:0] rnd_s;
    logic signed [W-1:0] sum_s;
    logic signed [W-1:0] shr_s;

    // One extra bit of headroom keeps acc + rounding constant from wrapping.
    always_comb begin
        ext_s = {acc_i[ACC_WIDTH-1], acc_i};
        if (shift_i != 5'd0) begin
            rnd_s = {{(W-1){1'b0}}, 1'b1} << (shift_i - 5'd1);
        end else begin
            rnd_s = '0;
        end
        sum_s = ext_s + rnd_s;
        shr_s = sum_s >>> shift_i;
        if (relu_en_i && (shr_s < 0)) begin
            res_o = '0;
        end else if (shr_s > SAT_MAX) begin
            res_o = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shr_s < SAT_MIN) begin
            res_o = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            res_o = shr_s[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mac_drain.sv
// Snapshots the PE accumulators on start, pulses clear_acc, then streams
// requantized rows 0..MAC_WIDTH-1 over a valid/ready interface.
module mac_drain
    import mac_pkg::*;
#(
    parameter int MAC_WIDTH = DEF_MAC_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators,
    input  logic [4:0]                             shift,
    input  logic                                   relu_en,
    output logic                                   clear_acc,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MAC_WIDTH*OUT_WIDTH-1:0]         out_data,
    output logic [$clog2(MAC_WIDTH)-1:0]           out_row,
    output logic                                   out_last
);

    localparam int ROW_W = $clog2(MAC_WIDTH);

    drain_state_e                           state_q;
    logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] snap_q;
    logic [4:0]                             shift_q;
    logic                                   relu_q;
    logic                                   clear_acc_q;
    logic                                   busy_q;
    logic                                   out_valid_q;
    logic                                   out_last_q;
    logic [MAC_WIDTH*OUT_WIDTH-1:0]         out_data_q;
    logic [ROW_W-1:0]                       out_row_q;

    logic [ROW_W-1:0]                       row_sel_s;
    logic [ACC_WIDTH-1:0]                   row_acc_s [MAC_WIDTH];
    logic [MAC_WIDTH*OUT_WIDTH-1:0]         row_res_s;

    // Row fed to the requantizers: row 0 while loading, otherwise the row after the one on display.
    always_comb begin
        if (state_q == LOAD) begin
            row_sel_s = '0;
        end else begin
            row_sel_s = out_row_q + {{(ROW_W-1){1'b0}}, 1'b1};
        end
        for (int j = 0; j < MAC_WIDTH; j++) begin
            row_acc_s[j] = snap_q[(int'(row_sel_s) * MAC_WIDTH + j) * ACC_WIDTH +: ACC_WIDTH];
        end
    end

    for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_col
        acc_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_requant (
            .acc_i     (row_acc_s[j]),
            .shift_i   (shift_q),
            .relu_en_i (relu_q),
            .res_o     (row_res_s[j*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Drain FSM with snapshot capture and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            shift_q     <= 5'd0;
            relu_q      <= 1'b0;
            clear_acc_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    clear_acc_q <= 1'b0;
                    if (start) begin
                        state_q     <= LOAD;
                        snap_q      <= accumulators;
                        shift_q     <= shift;
                        relu_q      <= relu_en;
                        clear_acc_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q     <= DRAIN;
                    clear_acc_q <= 1'b0;
                    out_data_q  <= row_res_s;
                    out_row_q   <= '0;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (MAC_WIDTH == 1);
                end
                DRAIN: begin
                    clear_acc_q <= 1'b0;
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_data_q <= row_res_s;
                            out_row_q  <= row_sel_s;
                            out_last_q <= (row_sel_s == ROW_W'(MAC_WIDTH - 1));
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    clear_acc_q <= 1'b0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clear_acc = clear_acc_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;

endmodule

// File: tb/tb_mac_drain.sv
// Directed self-checking bench for mac_drain with hand-computed row values.
module tb_mac_drain;

    localparam int MW = 8;
    localparam int AW = 32;
    localparam int OW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [MW*MW*AW-1:0] acc_v;
    logic [4:0]        shift_v;
    logic              relu_v;
    logic              clear_acc;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [MW*OW-1:0]  out_data;
    logic [2:0]        out_row;
    logic              out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;

    mac_drain #(.MAC_WIDTH(MW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .accumulators (acc_v),
        .shift        (shift_v),
        .relu_en      (relu_v),
        .clear_acc    (clear_acc),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clear_acc) clr_cnt <= clr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < MW*MW; i++) acc_v[i*AW +: AW] = v;
    endtask

    // Runs one full drain; row 0 must equal e0, every other row eo.
    task automatic drain(input string name, input logic [63:0] e0, input logic [63:0] eo,
                         input int stall_row, input int stall_n, input bit meddle);
        int nxt, stall_left, cyc, clr0, first_cyc;
        clr0 = clr_cnt; nxt = 0; stall_left = stall_n; cyc = 0; first_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_clr_load"}, clear_acc, 1);
        check_eq({name, "_busy_load"}, busy, 1);
        check_eq({name, "_valid_load"}, out_valid, 0);
        if (meddle) begin
            acc_v = ~acc_v;
            shift_v = 5'd0;
        end
        while (nxt < MW && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = meddle && (nxt == 3 || nxt == 7);
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check_eq({name, "_row"}, out_row, nxt);
                check_eq({name, "_data"}, out_data, (nxt == 0) ? e0 : eo);
                check_eq({name, "_last"}, out_last, (nxt == MW-1));
                check_eq({name, "_clr_drain"}, clear_acc, 0);
                if (out_row == stall_row && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    nxt++;
                end
            end
        end
        check_eq({name, "_rows_done"}, nxt, MW);
        check_eq({name, "_first_valid"}, first_cyc, 2);
        if (stall_n == 0) check_eq({name, "_cycles"}, cyc, MW + 1);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_busy_end"}, busy, 0);
        check_eq({name, "_valid_end"}, out_valid, 0);
        check_eq({name, "_last_end"}, out_last, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_idle_after"}, busy, 0);
        check_eq({name, "_clr_once"}, clr_cnt - clr0, 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b1; relu_v = 1'b0; shift_v = 5'd0; acc_v = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_clr", clear_acc, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_row", out_row, 0);
        check_eq("rst_data", out_data, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Uniform 256 >> 4 = 0x10, started in the first cycle out of reset.
        fill(32'd256); shift_v = 5'd4; relu_v = 1'b0;
        drain("basic", 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, -1, 0, 1'b0);

        // Saturation at shift 0, without and with ReLU.
        acc_v = '0; acc_v[31:0] = 32'd1000; acc_v[63:32] = 32'hFFFF_FC18; shift_v = 5'd0;
        drain("sat", 64'h0000_0000_0000_807F, 64'h0, -1, 0, 1'b0);
        relu_v = 1'b1;
        drain("relu", 64'h0000_0000_0000_007F, 64'h0, -1, 0, 1'b0);
        relu_v = 1'b0;

        // Rounding shifts, including the most negative accumulator at shift 31.
        acc_v = '0; acc_v[31:0] = 32'd23; acc_v[63:32] = 32'hFFFF_FFEC; shift_v = 5'd3;
        drain("round", 64'h0000_0000_0000_FE03, 64'h0, -1, 0, 1'b0);
        acc_v = '0; acc_v[31:0] = 32'h8000_0000; shift_v = 5'd31;
        drain("minacc", 64'h0000_0000_0000_00FF, 64'h0, -1, 0, 1'b0);

        // Backpressure: row 2 held for three cycles.
        fill(32'd256); shift_v = 5'd4;
        drain("stall", 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, 2, 3, 1'b0);

        // Inputs disturbed after the snapshot plus start pulses during the drain.
        fill(32'd256); shift_v = 5'd4;
        drain("snap", 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, -1, 0, 1'b1);

        // Asynchronous reset while row 3 is presented.
        fill(32'd256); shift_v = 5'd4;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_row == 3'd3) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_eq("rst_mid_row3", {out_valid, out_row}, {1'b1, 3'd3});
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", out_valid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_row", out_row, 0);
        check_eq("rst_mid_data", out_data, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drain("post_rst", 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
